// File: rtl/key_conditioner_pkg.sv
// Shared constants and types for the push-button conditioning front end.
package key_conditioner_pkg;
  localparam logic KEY_RELEASED = 1'b1;
  localparam logic KEY_PRESSED  = 1'b0;
  localparam int   DEBOUNCE_CYCLES_50MHZ = 1000000;

  localparam int KEY_RESET  = 0;
  localparam int KEY_SET    = 1;
  localparam int KEY_TOGGLE = 2;

  typedef struct packed {
    logic level;
    logic press;
    logic release_p;
    logic toggle;
  } key_out_t;
endpackage

// File: rtl/key_debounce_chan.sv
// One key: 2-flop synchronizer, stability counter, debounced level, edge pulses, gated toggle.
module key_debounce_chan
  import key_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
  parameter int CNT_W           = 20
) (
  input  logic     gclk,
  input  logic     grst_n,
  input  logic     raw_i,
  input  logic     tog_en_i,
  input  logic     tog_clr_i,
  output key_out_t out_o
);
  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q, lvl_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             tog_q, tog_d;
  logic             s, accept;

  assign s      = sync_q[1];
  assign accept = (s != lvl_q) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_comb begin
    cnt_d   = '0;
    lvl_d   = lvl_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    tog_d   = tog_q;
    if (accept) begin
      lvl_d   = s;
      press_d = (s == KEY_PRESSED);
      rel_d   = (s == KEY_RELEASED);
    end else if (s != lvl_q) begin
      cnt_d = cnt_q + 1'b1;
    end
    // clear wins over a press accepted in the same cycle
    if (tog_clr_i)                tog_d = 1'b0;
    else if (press_d && tog_en_i) tog_d = ~tog_q;
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      sync_q  <= {2{KEY_RELEASED}};
      cnt_q   <= '0;
      lvl_q   <= KEY_RELEASED;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      tog_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      tog_q   <= tog_d;
    end
  end

  assign out_o = '{level: lvl_q, press: press_q, release_p: rel_q, toggle: tog_q};
endmodule

// File: rtl/key_conditioner.sv
// Debounces all DE-board KEY inputs into clean level / press / release / toggle signals.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
  parameter int CNT_W           = 20
) (
  input  logic                CLOCK_50,
  input  logic                reset_btn,
  input  logic [NUM_KEYS-1:0] key_raw,
  input  logic [NUM_KEYS-1:0] toggle_en,
  input  logic [NUM_KEYS-1:0] toggle_clr,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_toggle
);
  // counter must reach DEBOUNCE_CYCLES-1 without wrapping
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2**CNT_W) - 1) begin : g_bad_cfg
    $fatal(1, "key_conditioner: DEBOUNCE_CYCLES=%0d out of range 2..2^CNT_W-1", DEBOUNCE_CYCLES);
  end

  key_out_t [NUM_KEYS-1:0] chan_out;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_chan (
      .gclk     (CLOCK_50),
      .grst_n   (reset_btn),
      .raw_i    (key_raw[k]),
      .tog_en_i (toggle_en[k]),
      .tog_clr_i(toggle_clr[k]),
      .out_o    (chan_out[k])
    );
    assign key_level[k]   = chan_out[k].level;
    assign key_press[k]   = chan_out[k].press;
    assign key_release[k] = chan_out[k].release_p;
    assign key_toggle[k]  = chan_out[k].toggle;
  end
endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: stability-run model compared every cycle plus directed literal checks.
module tb_key_conditioner;
  localparam int K  = 4;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [K-1:0] raw = '1, en = '0, clr = '0;
  logic [K-1:0] level, press, release_p, toggle;

  int n_chk = 0;
  int n_fail = 0;
  int pcnt = 0;

  key_conditioner #(.NUM_KEYS(K), .DEBOUNCE_CYCLES(DC), .CNT_W(20)) dut (
    .CLOCK_50   (clk),
    .reset_btn  (rst_n),
    .key_raw    (raw),
    .toggle_en  (en),
    .toggle_clr (clr),
    .key_level  (level),
    .key_press  (press),
    .key_release(release_p),
    .key_toggle (toggle)
  );

  always #5 clk = ~clk;

  // Model: a key's level follows the raw pin seen two edges late once it has
  // disagreed with the current level for DC edges in a row.
  logic [K-1:0] m_d1 = '1, m_d2 = '1, m_lvl = '1, m_prs = '0, m_rel = '0, m_tog = '0;
  int           m_run [K];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_d1 = '1; m_d2 = '1; m_lvl = '1; m_prs = '0; m_rel = '0; m_tog = '0;
      for (int k = 0; k < K; k++) m_run[k] = 0;
    end else begin
      for (int k = 0; k < K; k++) begin
        m_prs[k] = 1'b0;
        m_rel[k] = 1'b0;
        if (m_d2[k] != m_lvl[k]) begin
          m_run[k] = m_run[k] + 1;
          if (m_run[k] == DC) begin
            m_lvl[k] = m_d2[k];
            m_prs[k] = (m_d2[k] == 1'b0);
            m_rel[k] = (m_d2[k] == 1'b1);
            m_run[k] = 0;
          end
        end else begin
          m_run[k] = 0;
        end
        if (clr[k])                 m_tog[k] = 1'b0;
        else if (m_prs[k] && en[k]) m_tog[k] = ~m_tog[k];
      end
      m_d2 = m_d1;
      m_d1 = raw;
    end
  end

  task automatic chk(input string nm, input logic [K-1:0] a, input logic [K-1:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_level",   level,     m_lvl);
    chk("model_press",   press,     m_prs);
    chk("model_release", release_p, m_rel);
    chk("model_toggle",  toggle,    m_tog);
    if (press[1]) pcnt++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_rel(input int k);
    raw[k] = 1'b0; step(8);
    raw[k] = 1'b1; step(8);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;

    // 1: idle after reset
    step(20);
    chk("idle_level",   level,     4'b1111);
    chk("idle_press",   press,     4'b0000);
    chk("idle_release", release_p, 4'b0000);
    chk("idle_toggle",  toggle,    4'b0000);

    // 2: clean press on key 1
    raw[1] = 1'b0;
    step(5);
    chk("t2_press_c5", press, 4'b0000);
    chk("t2_level_c5", level, 4'b1111);
    step(1);
    chk("t2_press_c6", press, 4'b0010);
    chk("t2_level_c6", level, 4'b1101);
    step(1);
    chk("t2_press_c7", press, 4'b0000);

    // 3: release, then bounce low 3 / high 1 / low held
    raw[1] = 1'b1;
    step(6);
    chk("t3_release", release_p, 4'b0010);
    step(4);
    pcnt = 0;
    raw[1] = 1'b0; step(3);
    raw[1] = 1'b1; step(1);
    raw[1] = 1'b0;
    step(5);
    chk("t3_press_c5", press, 4'b0000);
    step(1);
    chk("t3_press_c6", press, 4'b0010);
    step(3);
    chk("t3_one_press", 4'(pcnt), 4'd1);

    // 4: toggle gating on key 2
    en[2] = 1'b1;
    press_rel(2);
    chk("t4_tog1", toggle, 4'b0100);
    press_rel(2);
    chk("t4_tog2", toggle, 4'b0000);
    en[2] = 1'b0;
    press_rel(2);
    chk("t4_tog3", toggle, 4'b0000);

    // 5: clear coincident with an enabled press
    en[2] = 1'b1;
    press_rel(2);
    chk("t5_tog_set", toggle, 4'b0100);
    raw[2] = 1'b0;
    step(5);
    clr[2] = 1'b1;
    step(1);
    chk("t5_press", press, 4'b0100);
    chk("t5_clr", toggle, 4'b0000);
    clr[2] = 1'b0;
    raw[2] = 1'b1;
    step(8);
    en[2] = 1'b0;

    // 6: reset while key 0 is mid-count (key 1 still held low)
    raw[0] = 1'b0;
    step(4);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_level",   level,     4'b1111);
    chk("t6_rst_press",   press,     4'b0000);
    chk("t6_rst_release", release_p, 4'b0000);
    chk("t6_rst_toggle",  toggle,    4'b0000);
    step(2);
    rst_n = 1'b1;
    step(5);
    chk("t6_press_c5", press, 4'b0000);
    step(1);
    chk("t6_press_c6", press, 4'b0011);
    chk("t6_level_c6", level, 4'b1100);
    step(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
